// File: rtl/avgpool2d_stream_ctrl.sv
// avgpool2d_stream_ctrl: streaming KxK average-pool sequencer (stride = K).
// Accepts a channel-major raster pixel stream for one frame per start pulse.
// Each window is summed in a per-column accumulator bank, and a pooled row is
// drained as a valid/ready stream once its last input pixel has arrived.
// Optional feature: define AVGPOOL_CTRL_STALL_CNT_EN to add the stall_cnt
// output port, which counts back-pressure cycles and input-starved cycles.
module avgpool2d_stream_ctrl #(
  parameter int CH    = 1,
  parameter int IN_H  = 4,
  parameter int IN_W  = 4,
  parameter int K     = 2,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int OUT_H     = IN_H / K;
  localparam int OUT_W     = IN_W / K;
  localparam int D         = K * K;
  localparam int ACC_WIDTH = WIDTH + $clog2(D) + 1;
  localparam int RW        = ACC_WIDTH + 1;
  localparam int WW        = $clog2(IN_W + 1);
  localparam int HW        = $clog2(IN_H + 1);
  localparam int CW        = $clog2(CH + 1);
  localparam int KW        = $clog2(K + 1);
  localparam int OW        = $clog2(OUT_W + 1);

  if (K < 1 || K > IN_H || K > IN_W) begin : g_bad_k
    $error("avgpool2d_stream_ctrl: K must satisfy 1 <= K <= IN_H and K <= IN_W");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                       state, state_nx;
  logic [WW-1:0]                w;
  logic [HW-1:0]                h;
  logic [CW-1:0]                c;
  logic [KW-1:0]                wk, hk;
  logic [OW-1:0]                ow, ld_idx, out_idx;
  logic signed [ACC_WIDTH-1:0]  acc [OUT_W];
  logic signed [ACC_WIDTH-1:0]  acc_sel;
  logic signed [ACC_WIDTH-1:0]  px_ext;
  logic                         frame_end, drain_last;
  logic                         accept, last_col, last_row, last_ch, in_win;
  logic                         drain_hit, frame_hit, hs, last_hs, load;

  // Round half away from zero: divide |acc| by D, then restore the sign.
  function automatic logic signed [WIDTH-1:0] round_avg(input logic signed [ACC_WIDTH-1:0] a);
    logic [RW-1:0]    ax, m;
    logic [WIDTH-1:0] mag;
    ax  = {a[ACC_WIDTH-1], a};
    m   = a[ACC_WIDTH-1] ? (~ax + RW'(1)) : ax;
    mag = WIDTH'((m + RW'(D / 2)) / RW'(D));
    return a[ACC_WIDTH-1] ? (~mag + WIDTH'(1)) : mag;
  endfunction

  assign px_ext    = {{(ACC_WIDTH - WIDTH){in_data[WIDTH-1]}}, in_data};
  assign accept    = (state == ACCUM) && in_valid;
  assign last_col  = (w == WW'(IN_W - 1));
  assign last_row  = (h == HW'(IN_H - 1));
  assign last_ch   = (c == CW'(CH - 1));
  assign in_win    = (h < HW'(OUT_H * K)) && (w < WW'(OUT_W * K));
  assign drain_hit = accept && last_col && (hk == KW'(K - 1)) && (h < HW'(OUT_H * K));
  assign frame_hit = accept && last_col && last_row && last_ch;
  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && (out_idx == OW'(OUT_W - 1));
  assign load      = (state == DRAIN) && (ld_idx < OW'(OUT_W)) && (!out_valid || out_ready);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign in_ready  = (state == ACCUM);

  // Select the accumulator being loaded into the output register.
  always_comb begin
    acc_sel = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (ld_idx == OW'(i)) acc_sel = acc[i];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; a drain takes priority over frame end when the last pixel closes a window row.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: begin
        if (drain_hit)      state_nx = DRAIN;
        else if (frame_hit) state_nx = DONE;
      end
      DRAIN: if (last_hs) state_nx = frame_end ? DONE : ACCUM;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Raster counters, frame/drain flags and the accumulator bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0; h <= '0; c <= '0; wk <= '0; hk <= '0; ow <= '0;
      frame_end <= 1'b0; drain_last <= 1'b0;
      for (int unsigned i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else if (state == IDLE) begin
      w <= '0; h <= '0; c <= '0; wk <= '0; hk <= '0; ow <= '0;
      frame_end <= 1'b0; drain_last <= 1'b0;
      for (int unsigned i = 0; i < OUT_W; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        if (last_col) begin
          w <= '0; wk <= '0; ow <= '0;
          if (last_row) begin
            h <= '0; hk <= '0;
            c <= last_ch ? '0 : c + CW'(1);
          end else begin
            h  <= h + HW'(1);
            hk <= (hk == KW'(K - 1)) ? '0 : hk + KW'(1);
          end
        end else begin
          w <= w + WW'(1);
          if (wk == KW'(K - 1)) begin
            wk <= '0;
            ow <= ow + OW'(1);
          end else begin
            wk <= wk + KW'(1);
          end
        end
      end
      if (frame_hit) frame_end <= 1'b1;
      if (drain_hit) drain_last <= (h == HW'(OUT_H * K - 1)) && last_ch;
      for (int unsigned i = 0; i < OUT_W; i++) begin
        if (accept && in_win && ow == OW'(i))  acc[i] <= acc[i] + px_ext;
        else if (hs && out_idx == OW'(i))      acc[i] <= '0;
      end
    end
  end

  // Output register: loads the next entry when empty or when the held one is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; out_data <= '0; out_last <= 1'b0;
      ld_idx <= '0; out_idx <= '0;
    end else if (drain_hit) begin
      ld_idx <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= round_avg(acc_sel);
      out_last  <= drain_last && (ld_idx == OW'(OUT_W - 1));
      out_idx   <= ld_idx;
      ld_idx    <= ld_idx + OW'(1);
    end else if (hs) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef AVGPOOL_CTRL_STALL_CNT_EN
  // Saturating count of output back-pressure and input-starved cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   stall_cnt <= '0;
    else if (state == IDLE && start)                           stall_cnt <= '0;
    else if (((out_valid && !out_ready) || (state == ACCUM && !in_valid)) &&
             stall_cnt != '1)                                  stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_avgpool2d_stream_ctrl.sv
// Directed testbench for avgpool2d_stream_ctrl: default 4x4/K=2 instance,
// a 5x5 instance (trailing row/column) and a two-channel instance.
module tb_avgpool2d_stream_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] in_data = '0;

  logic [2:0]  st_v, busy_v, done_v, ir_v, ov_v, ol_v;
  logic [15:0] od0, od1, od2;
  logic        cur_busy, cur_done, cur_ir, cur_ov, cur_ol;
  logic [15:0] cur_od;
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
  logic [31:0] sc0, sc1, sc2;
`endif

  int checks = 0, failures = 0;

  logic [15:0] pix [64];
  logic [15:0] got [16];
  logic        got_last [16];
  int          nout, done_cyc, last_hs_cyc, last_acc_cyc, acc_at_done;
  int          hold_bad, busy_gap;
  logic [15:0] held_val;
  bit          timed_out, idle_after;

  always_comb begin
    st_v = '0;
    case (sel)
      1: begin st_v[1] = start; cur_busy = busy_v[1]; cur_done = done_v[1]; cur_ir = ir_v[1];
               cur_ov = ov_v[1]; cur_ol = ol_v[1]; cur_od = od1; end
      2: begin st_v[2] = start; cur_busy = busy_v[2]; cur_done = done_v[2]; cur_ir = ir_v[2];
               cur_ov = ov_v[2]; cur_ol = ol_v[2]; cur_od = od2; end
      default: begin st_v[0] = start; cur_busy = busy_v[0]; cur_done = done_v[0]; cur_ir = ir_v[0];
               cur_ov = ov_v[0]; cur_ol = ol_v[0]; cur_od = od0; end
    endcase
  end

  avgpool2d_stream_ctrl #(.CH(1), .IN_H(4), .IN_W(4), .K(2), .WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .start(st_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .in_valid(in_valid), .in_ready(ir_v[0]), .in_data(in_data),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_data(od0), .out_last(ol_v[0])
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
    , .stall_cnt(sc0)
`endif
  );

  avgpool2d_stream_ctrl #(.CH(1), .IN_H(5), .IN_W(5), .K(2), .WIDTH(16)) dut5 (
    .clk(clk), .rst(rst), .start(st_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .in_valid(in_valid), .in_ready(ir_v[1]), .in_data(in_data),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_data(od1), .out_last(ol_v[1])
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );

  avgpool2d_stream_ctrl #(.CH(2), .IN_H(4), .IN_W(4), .K(2), .WIDTH(16)) dutc (
    .clk(clk), .rst(rst), .start(st_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .in_valid(in_valid), .in_ready(ir_v[2]), .in_data(in_data),
    .out_valid(ov_v[2]), .out_ready(out_ready), .out_data(od2), .out_last(ol_v[2])
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );

  // Drives one frame into the selected instance and records what comes back.
  task automatic run_frame(input int n_in, input int hold, input bit poke);
    int pi, cyc, hleft;
    bit first_seen;
    nout = 0; done_cyc = -100; last_hs_cyc = -1; last_acc_cyc = -1; acc_at_done = -1;
    timed_out = 0; hold_bad = 0; held_val = '0; busy_gap = 0; idle_after = 0;
    hleft = hold; first_seen = 0; pi = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (1) begin
      if (cur_done) begin done_cyc = cyc; acc_at_done = pi; break; end
      if (!cur_busy) busy_gap++;
      if (cyc >= 1000) begin timed_out = 1; break; end
      in_valid = (pi < n_in);
      in_data  = (pi < n_in) ? pix[pi] : 16'h0;
      start    = poke;
      if (in_valid && cur_ir) begin pi++; last_acc_cyc = cyc; end
      if (cur_ov && hleft > 0) begin
        if (!first_seen) begin first_seen = 1; held_val = cur_od; end
        else if (cur_od !== held_val || cur_ir !== 1'b0) hold_bad++;
        out_ready = 1'b0;
        hleft--;
      end else begin
        out_ready = 1'b1;
      end
      if (cur_ov && out_ready) begin
        if (nout < 16) begin got[nout] = cur_od; got_last[nout] = cur_ol; end
        nout++;
        last_hs_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    idle_after = !cur_busy && !cur_done;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) pix[i] = 16'(i + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_v[0]); end
    checks++; if (done_v[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_v[0]); end
    checks++; if (ir_v[0] !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", ir_v[0]); end
    checks++; if (ov_v[0] !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov_v[0]); end
    checks++; if (ol_v[0] !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", ol_v[0]); end
    checks++; if (od0 !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", od0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy_v[0]); end
  endtask

  task automatic test_basic();
    logic [15:0] e [4] = '{16'd4, 16'd6, 16'd12, 16'd14};
    sel = 0; load_ramp();
    run_frame(16, 0, 0);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", timed_out); end
    checks++; if (nout !== 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", nout); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", k, got[k], e[k]); end
      checks++; if (got_last[k] !== (k == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", k, got_last[k], k == 3); end
    end
    checks++; if (done_cyc - last_hs_cyc !== 1) begin failures++; $display("FAIL basic_done_lat got=%0d exp=1", done_cyc - last_hs_cyc); end
    checks++; if (idle_after !== 1'b1) begin failures++; $display("FAIL basic_idle got=%b exp=1", idle_after); end
  endtask

  task automatic test_rounding();
    logic [15:0] rows [16] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                               16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE,
                               16'h7FFF, 16'h7FFF, 16'h0001, 16'h0001,
                               16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000};
    logic [15:0] e [4] = '{16'hFFFF, 16'hFFFE, 16'h7FFF, 16'h0001};
    sel = 0;
    for (int i = 0; i < 16; i++) pix[i] = rows[i];
    run_frame(16, 0, 0);
    checks++; if (nout !== 4) begin failures++; $display("FAIL round_count got=%0d exp=4", nout); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL round_data[%0d] got=%h exp=%h", k, got[k], e[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e [4] = '{16'd4, 16'd6, 16'd12, 16'd14};
    sel = 0; load_ramp();
    run_frame(16, 5, 0);
    checks++; if (held_val !== 16'd4) begin failures++; $display("FAIL bp_held got=%h exp=0004", held_val); end
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL bp_hold_unstable got=%0d exp=0", hold_bad); end
    checks++; if (nout !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", nout); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", k, got[k], e[k]); end
    end
`ifdef AVGPOOL_CTRL_STALL_CNT_EN
    checks++; if (sc0 < 32'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp>=5", sc0); end
`endif
  endtask

  task automatic test_trailing();
    sel = 1;
    for (int hh = 0; hh < 5; hh++)
      for (int ww = 0; ww < 5; ww++)
        pix[hh * 5 + ww] = (hh == 4 || ww == 4) ? 16'd1000 : 16'd1;
    run_frame(25, 0, 0);
    checks++; if (nout !== 4) begin failures++; $display("FAIL trail_count got=%0d exp=4", nout); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== 16'd1) begin failures++; $display("FAIL trail_data[%0d] got=%h exp=0001", k, got[k]); end
    end
    checks++; if (busy_gap !== 0) begin failures++; $display("FAIL trail_busy_gap got=%0d exp=0", busy_gap); end
    checks++; if (acc_at_done !== 25) begin failures++; $display("FAIL trail_pixels_at_done got=%0d exp=25", acc_at_done); end
    checks++; if (done_cyc - last_acc_cyc !== 1) begin failures++; $display("FAIL trail_done_lat got=%0d exp=1", done_cyc - last_acc_cyc); end
    checks++; if (idle_after !== 1'b1) begin failures++; $display("FAIL trail_idle got=%b exp=1", idle_after); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] e [4] = '{16'd4, 16'd6, 16'd12, 16'd14};
    int dones;
    sel = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (busy_v[0] !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy_v[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_v[0] !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_v[0]); end
    checks++; if (ov_v[0] !== 1'b0) begin failures++; $display("FAIL abort_out_valid got=%b exp=0", ov_v[0]); end
    checks++; if (done_v[0] !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done_v[0]); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_spurious_done got=%0d exp=0", dones); end
    load_ramp();
    run_frame(16, 0, 0);
    checks++; if (nout !== 4) begin failures++; $display("FAIL abort_refr_count got=%0d exp=4", nout); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL abort_refr_data[%0d] got=%h exp=%h", k, got[k], e[k]); end
    end
  endtask

  task automatic test_multi_channel();
    logic [15:0] e [8] = '{16'd4, 16'd6, 16'd12, 16'd14,
                           16'hFFFC, 16'hFFFA, 16'hFFF4, 16'hFFF2};
    sel = 2;
    for (int i = 0; i < 16; i++) begin
      pix[i]      = 16'(i + 1);
      pix[i + 16] = 16'(-(i + 1));
    end
    run_frame(32, 0, 1);
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL mc_timeout got=%b exp=0", timed_out); end
    checks++; if (nout !== 8) begin failures++; $display("FAIL mc_count got=%0d exp=8", nout); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL mc_data[%0d] got=%h exp=%h", k, got[k], e[k]); end
      checks++; if (got_last[k] !== (k == 7)) begin failures++; $display("FAIL mc_last[%0d] got=%b exp=%b", k, got_last[k], k == 7); end
    end
    checks++; if (idle_after !== 1'b1) begin failures++; $display("FAIL mc_idle got=%b exp=1", idle_after); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e [4] = '{16'd4, 16'd6, 16'd12, 16'd14};
    sel = 0;
    for (int r = 0; r < 2; r++) begin
      load_ramp();
      run_frame(16, 0, 0);
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] !== e[k]) begin failures++; $display("FAIL b2b_data[%0d][%0d] got=%h exp=%h", r, k, got[k], e[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_trailing();
    test_reset_abort();
    test_multi_channel();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
